instr_register_alu: RTL and testbench
=====================================

# instr_register_alu

Parametrised successor of the instruction register. It stores opcode/operand instructions in a register stack of configurable depth and operand width. It computes each instruction's result in a one-stage pipeline before commit, and returns instruction, result, valid and error status on a combinational read port. It sits between the instruction-generating testbench/stimulus side and any consumer reading back executed instructions.

## Interface
Parameters:
- OP_WIDTH, 32, operand width in bits (signed)
- DEPTH, 32, number of register-stack entries (need not be a power of 2)
- ADDR_WIDTH, $clog2(DEPTH), pointer width
- RES_WIDTH, 2*OP_WIDTH, result width (signed)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  input  1  clock; all state changes on rising edge
  - reset_n  input  1  asynchronous, active-low reset
- Write side:
  - load_en  input  1  capture a write this cycle
  - opcode  input  opcode_t  operation to store/execute
  - operand_a  input  OP_WIDTH  signed operand A
  - operand_b  input  OP_WIDTH  signed operand B
  - write_pointer  input  ADDR_WIDTH  destination entry
- Read side:
  - read_pointer  input  ADDR_WIDTH  entry to read
  - instruction_word  output  instr_result_t  {opc, op_a, op_b, result, valid, div_err} of entry read_pointer
- Status:
  - valid_count  output  ADDR_WIDTH+1  number of entries with valid=1

## Operation
- Stage 1 (capture): on a rising edge with load_en=1, latch opcode, operand_a, operand_b and write_pointer into a pipeline register, and set pipe_valid=1. With load_en=0, pipe_valid=0.
- Stage 2 (commit): on the next rising edge, if pipe_valid=1, compute the result from the pipeline register and write the full entry with valid=1.
- ALU rules (all signed, sign-extended to RES_WIDTH):
  - ZERO → 0
  - PASSA → a
  - PASSB → b
  - ADD → a+b
  - SUB → a−b
  - MULT → full a*b
  - DIV → a/b, truncated toward zero
  - MOD → a%b, sign of a
- DIV/MOD with b=0: result=0 and div_err=1. div_err=0 in every other case.
- DIV with a = most-negative and b = −1 gives +2^(OP_WIDTH−1); it fits in RES_WIDTH, so there is no error.
- Read is combinational: instruction_word reflects the stored entry at read_pointer.
- An entry never written since reset reads as all-zero, with valid=0.
- write_pointer ≥ DEPTH: the capture still occurs, but the commit is dropped and there is no state change. read_pointer ≥ DEPTH returns all-zero.
- valid_count:
  - +1 when a commit lands on an entry with valid=0
  - unchanged when a commit overwrites a valid entry
  - saturates at DEPTH by construction

## Timing
- Reset (async assert, sync release): every entry is cleared to zero with valid=0, pipe_valid=0 and valid_count=0. instruction_word therefore reads all-zero.
- Write latency:
  - load_en sampled at edge N
  - entry committed at edge N+1
  - visible on instruction_word after edge N+1
- Back-to-back writes (load_en high for consecutive cycles) sustain one commit per cycle. There are no stalls.
- Read in the same cycle as a commit to the same address returns the old contents until the edge. Same-address back-to-back writes: the later one wins.
- Reset asserted with pipe_valid=1: the in-flight write is discarded and never commits.

## Structure
- Extend instr_register_pkg:
  - opcode_t (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD)
  - parameterised operand/result widths via localparam defaults
  - instr_result_t struct {opc, op_a, op_b, result, valid, div_err}
- Sub-module instr_alu: purely combinational {opcode, a, b} → {result, div_err}, instanced in stage 2.
- Storage is a flop array, because the asynchronous clear requires it. valid_count is a registered counter, not a popcount.

## Test plan
- Reset, then read all DEPTH entries → each all-zero with valid=0; valid_count=0.
- Write addr 0 ADD a=5 b=−7 at edge N → read 0 shows result=−2 and valid=1 after N+1, not after N; valid_count=1.
- Write DIV a=−9 b=2 at addr 1 and MOD a=−9 b=2 at addr 2 → results −4 and −1. Write DIV a=7 b=0 at addr 3 → result=0, div_err=1.
- Write MULT with OP_WIDTH=32: a=−2^31, b=−2^31 → result=2^62, with no truncation.
- Three back-to-back writes to addr 4 (PASSA 1, 2, 3) → final read 3; valid_count rises by 1 only. Write to addr DEPTH → no entry changes.
- Assert reset_n low one cycle after load_en (mid-pipeline) → after release all entries are invalid and valid_count=0.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register with integrated ALU:
// opcode encoding, default operand/result widths and the read-port record.
package instr_register_pkg;

    localparam int OP_WIDTH_DEF  = 32;
    localparam int RES_WIDTH_DEF = 2 * OP_WIDTH_DEF;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [OP_WIDTH_DEF-1:0]  operand_t;
    typedef logic signed [RES_WIDTH_DEF-1:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
        logic     valid;
        logic     div_err;
    } instr_result_t;

    function automatic logic is_div_op(input opcode_t opc);
        return (opc == DIV) || (opc == MOD);
    endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational signed ALU: {opcode, a, b} -> {result, div_err}.
// Operands are sign-extended to RES_WIDTH first so MULT and DIV never overflow.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = OP_WIDTH_DEF,
    parameter int RES_WIDTH = 2 * OP_WIDTH
) (
    input  opcode_t                      opcode,
    input  logic signed [OP_WIDTH-1:0]   a,
    input  logic signed [OP_WIDTH-1:0]   b,
    output logic signed [RES_WIDTH-1:0]  result,
    output logic                         div_err
);

    logic signed [RES_WIDTH-1:0] a_ext;
    logic signed [RES_WIDTH-1:0] b_ext;
    logic signed [RES_WIDTH-1:0] divisor;
    logic                        b_is_zero;

    always_comb begin
        a_ext     = RES_WIDTH'(a);
        b_ext     = RES_WIDTH'(b);
        b_is_zero = (b == '0);
        // Divider never sees zero; the guarded result is discarded below.
        divisor   = b_is_zero ? RES_WIDTH'(1) : b_ext;
        result    = '0;
        div_err   = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV:   result = a_ext / divisor;
            MOD:   result = a_ext % divisor;
            default: result = '0;
        endcase
        if (is_div_op(opcode) && b_is_zero) begin
            result  = '0;
            div_err = 1'b1;
        end
    end

endmodule

// File: rtl/instr_register_alu.sv
// Register stack of executed instructions: capture stage, ALU + commit stage,
// combinational read port and a registered count of valid entries.
module instr_register_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH   = OP_WIDTH_DEF,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RES_WIDTH  = 2 * OP_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load_en,
    input  opcode_t                     opcode,
    input  logic signed [OP_WIDTH-1:0]  operand_a,
    input  logic signed [OP_WIDTH-1:0]  operand_b,
    input  logic [ADDR_WIDTH-1:0]       write_pointer,
    input  logic [ADDR_WIDTH-1:0]       read_pointer,
    output instr_result_t               instruction_word,
    output logic [ADDR_WIDTH:0]         valid_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    opcode_t                     opc_p1;
    logic signed [OP_WIDTH-1:0]  a_p1;
    logic signed [OP_WIDTH-1:0]  b_p1;
    logic [ADDR_WIDTH-1:0]       wptr_p1;
    logic                        vld_p1;

    logic signed [RES_WIDTH-1:0] res_p1;
    logic                        err_p1;
    logic                        commit;
    logic                        first_fill;

    opcode_t                     opc_mem   [DEPTH];
    logic signed [OP_WIDTH-1:0]  a_mem     [DEPTH];
    logic signed [OP_WIDTH-1:0]  b_mem     [DEPTH];
    logic signed [RES_WIDTH-1:0] res_mem   [DEPTH];
    logic                        valid_mem [DEPTH];
    logic                        err_mem   [DEPTH];

    // ---- stage 1: capture ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= load_en;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            opc_p1  <= opcode;
            a_p1    <= operand_a;
            b_p1    <= operand_b;
            wptr_p1 <= write_pointer;
        end
    end

    // ---- stage 2: execute and commit ----
    instr_alu #(
        .OP_WIDTH  (OP_WIDTH),
        .RES_WIDTH (RES_WIDTH)
    ) u_alu (
        .opcode  (opc_p1),
        .a       (a_p1),
        .b       (b_p1),
        .result  (res_p1),
        .div_err (err_p1)
    );

    assign commit     = vld_p1 && ({1'b0, wptr_p1} < DEPTH_LIM);
    assign first_fill = commit && !valid_mem[wptr_p1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                opc_mem[i]   <= ZERO;
                a_mem[i]     <= '0;
                b_mem[i]     <= '0;
                res_mem[i]   <= '0;
                valid_mem[i] <= 1'b0;
                err_mem[i]   <= 1'b0;
            end
        end else if (commit) begin
            opc_mem[wptr_p1]   <= opc_p1;
            a_mem[wptr_p1]     <= a_p1;
            b_mem[wptr_p1]     <= b_p1;
            res_mem[wptr_p1]   <= res_p1;
            valid_mem[wptr_p1] <= 1'b1;
            err_mem[wptr_p1]   <= err_p1;
        end
    end

    // Only first fills of an entry move the count, so it cannot exceed DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_count <= '0;
        end else if (first_fill) begin
            valid_count <= valid_count + COUNT_ONE;
        end
    end

    // ---- read port ----
    always_comb begin
        instruction_word = '0;
        if ({1'b0, read_pointer} < DEPTH_LIM) begin
            instruction_word.opc     = opc_mem[read_pointer];
            instruction_word.op_a    = OP_WIDTH_DEF'(a_mem[read_pointer]);
            instruction_word.op_b    = OP_WIDTH_DEF'(b_mem[read_pointer]);
            instruction_word.result  = RES_WIDTH_DEF'(res_mem[read_pointer]);
            instruction_word.valid   = valid_mem[read_pointer];
            instruction_word.div_err = err_mem[read_pointer];
        end
    end

endmodule

// File: tb/tb_instr_register_alu.sv
// Bench for instr_register_alu: table-driven ALU vectors through a scoreboard,
// plus hand-written back-to-back, out-of-range and mid-pipeline reset sequences.
module tb_instr_register_alu;
    import instr_register_pkg::*;

    localparam int OPW   = 32;
    localparam int DEPTH = 20;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = 2 * OPW;
    localparam int NV    = 12;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   load_en;
    opcode_t                opcode;
    logic signed [OPW-1:0]  operand_a;
    logic signed [OPW-1:0]  operand_b;
    logic [AW-1:0]          write_pointer;
    logic [AW-1:0]          read_pointer;
    instr_result_t          instruction_word;
    logic [AW:0]            valid_count;

    always #5 clk = ~clk;

    instr_register_alu #(
        .OP_WIDTH   (OPW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .RES_WIDTH  (RW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .valid_count      (valid_count)
    );

    typedef struct {
        opcode_t opc;
        int      a;
        int      b;
        int      addr;
        longint  res;
        bit      err;
    } vec_t;

    typedef struct {
        int            addr;
        instr_result_t exp;
    } sb_t;

    vec_t          vecs [NV];
    sb_t           sb_q [$];
    instr_result_t model [DEPTH];
    int            passed = 0;
    int            total  = 0;

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(model[i].valid);
        return n;
    endfunction

    task automatic check_word(input string name, input instr_result_t act, input instr_result_t exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input opcode_t o, input int a, input int b, input int addr,
                         input longint res, input bit err);
        sb_t e;
        @(negedge clk);
        opcode        = o;
        operand_a     = a;
        operand_b     = b;
        write_pointer = AW'(addr);
        load_en       = 1'b1;
        e.addr          = addr;
        e.exp.opc       = o;
        e.exp.op_a      = a;
        e.exp.op_b      = b;
        e.exp.result    = res;
        e.exp.valid     = 1'b1;
        e.exp.div_err   = err;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string name);
        sb_t           e;
        instr_result_t exp;
        if (sb_q.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty, got %h", name, instruction_word);
            return;
        end
        e   = sb_q.pop_front();
        exp = '0;
        if (e.addr < DEPTH) begin
            model[e.addr] = e.exp;
            exp = e.exp;
        end
        read_pointer = AW'(e.addr);
        #1;
        check_word(name, instruction_word, exp);
        check_int({name, "_count"}, int'(valid_count), model_count());
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            read_pointer = AW'(i);
            #1;
            check_word(name, instruction_word, model[i]);
        end
        check_int({name, "_count"}, int'(valid_count), model_count());
    endtask

    initial begin
        reset_n       = 1'b0;
        load_en       = 1'b0;
        opcode        = ZERO;
        operand_a     = '0;
        operand_b     = '0;
        write_pointer = '0;
        read_pointer  = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        vecs[0]  = '{ADD,   5,            -7,  0, -2,                       1'b0};
        vecs[1]  = '{DIV,   -9,           2,   1, -4,                       1'b0};
        vecs[2]  = '{MOD,   -9,           2,   2, -1,                       1'b0};
        vecs[3]  = '{DIV,   7,            0,   3, 0,                        1'b1};
        vecs[4]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 5, 64'h4000_0000_0000_0000, 1'b0};
        vecs[5]  = '{SUB,   3,            10,  6, -7,                       1'b0};
        vecs[6]  = '{PASSB, 9,            -5,  7, -5,                       1'b0};
        vecs[7]  = '{ZERO,  9,            9,   8, 0,                        1'b0};
        vecs[8]  = '{DIV,   32'h8000_0000, -1, 9, 64'h0000_0000_8000_0000, 1'b0};
        vecs[9]  = '{MOD,   7,            0,   10, 0,                       1'b1};
        vecs[10] = '{PASSA, 123,          -4,  11, 123,                     1'b0};
        vecs[11] = '{MOD,   9,            -2,  12, 1,                       1'b0};

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_all("reset");

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].addr, vecs[i].res, vecs[i].err);
            @(negedge clk);
            load_en      = 1'b0;
            read_pointer = AW'(vecs[i].addr);
            #1;
            check_word("pre_commit", instruction_word, model[vecs[i].addr]);
            @(negedge clk);
            pop_check("vector");
        end

        // back-to-back writes to one address; the middle read lands on a commit cycle
        drive(PASSA, 1, 0, 4, 1, 1'b0);
        drive(PASSA, 2, 0, 4, 2, 1'b0);
        drive(PASSA, 3, 0, 4, 3, 1'b0);
        pop_check("b2b_first");
        @(negedge clk);
        load_en = 1'b0;
        pop_check("b2b_second");
        @(negedge clk);
        pop_check("b2b_final");

        // write beyond DEPTH is captured but never commits
        drive(PASSB, 55, 66, DEPTH, 66, 1'b0);
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        pop_check("oob_read");
        check_all("oob_intact");
        read_pointer = AW'(31);
        #1;
        check_word("oob_read_31", instruction_word, '0);

        // reset lands while a write sits in the pipeline register
        @(negedge clk);
        opcode        = PASSA;
        operand_a     = 77;
        operand_b     = 0;
        write_pointer = AW'(13);
        load_en       = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check_int("reset_mid_count", int'(valid_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        check_all("reset_mid");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
